systolic_tile_scheduler: RTL and testbench
==========================================

SYSTOLIC_TILE_SCHEDULER -- requirements
Module: systolic_tile_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning generator base-address width.
REQ-002 SHALL have parameter WIDTH_HEIGHT, default 16, meaning array dimension; CW = $clog2(WIDTH_HEIGHT).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 31, meaning array pipeline drain cycles; legal range 1..255.
REQ-004 SHALL have parameter TIMEOUT, default 1023, meaning max cycles waiting for a generator done; legal range 1..1023.
REQ-005 SHALL have ports, one per line:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  tile command present.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_w_base, cmd_x_base, cmd_y_base  in  ADDR_WIDTH each  weight, input and output base addresses.
- cmd_num_row, cmd_num_col  in  CW each  tile extent, passed to the generators.
- w_active, x_active, y_active  out  1 each  start pulses to the weight, input and output address generators.
- w_done, x_done, y_done  in  1 each  generator done levels.
- gen_base  out  ADDR_WIDTH  shared base-address bus to the generators.
- gen_num_row, gen_num_col  out  CW each  shared extent bus.
- busy  out  1  tile in progress.
- phase  out  3  current state encoding.
- tile_done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Function
REQ-006 SHALL implement the states IDLE=0, LOAD_W=1, FEED_X=2, FLUSH=3, DRAIN_Y=4 and FINISH=5; phase SHALL equal the state register.
REQ-007 cmd_ready SHALL be 1 only in IDLE.
REQ-008 Accept SHALL occur when cmd_valid & cmd_ready at a clock edge; all five cmd fields SHALL be latched and the next state SHALL be LOAD_W.
REQ-009 Each x_active output SHALL be high for exactly the first cycle of its own state (w in LOAD_W, x in FEED_X, y in DRAIN_Y) and 0 otherwise.
REQ-010 The matching x_done SHALL be ignored during the active cycle and sampled from the next cycle on; done=1 at a sampled edge advances LOAD_W->FEED_X, FEED_X->FLUSH, DRAIN_Y->FINISH.
REQ-011 FLUSH SHALL last exactly FLUSH_CYCLES cycles (8-bit down-counter loaded on entry), then go to DRAIN_Y.
REQ-012 FINISH SHALL last one cycle with tile_done=1, then go to IDLE.
REQ-013 gen_base SHALL be registered: w_base in LOAD_W, x_base in FEED_X, y_base in DRAIN_Y, and 0 otherwise.
REQ-014 gen_base SHALL be valid in the same cycle as the corresponding active.
REQ-015 gen_num_row and gen_num_col SHALL output the latched values and stay stable from accept until FINISH exits.
REQ-016 busy SHALL be 1 in all states except IDLE.
REQ-017 A 10-bit wait counter SHALL clear on entry to LOAD_W, FEED_X and DRAIN_Y, and increment each cycle in those states.
REQ-018 If the wait counter reaches TIMEOUT without done, err SHALL set and the state SHALL go to IDLE next cycle, with no tile_done.
REQ-019 err SHALL stay set until reset or the next accepted command, which clears it.
REQ-020 cmd_valid outside IDLE SHALL be ignored; the command is not lost if the requester holds it.
REQ-021 Done inputs not matching the current state SHALL be ignored.
REQ-022 Back-to-back operation: cmd_ready SHALL be 1 in the cycle after FINISH, so a new tile is accepted no sooner than 1 cycle after tile_done.

Reset
REQ-023 reset SHALL override all other inputs at the same edge and return the state to IDLE.
REQ-024 After reset: all active outputs 0, tile_done=0, err=0, busy=0, phase=0, gen_base=0, gen_num_row/col=0, all counters 0, cmd_ready=1.
REQ-025 reset mid-tile SHALL abort the tile with no active or tile_done pulse in the following cycle.

Verification
REQ-026 Nominal: accept at edge 0 (w_base=0x10, x_base=0x40, y_base=0x80, rows=15, cols=15); generator done 4 cycles after each active -> w_active cycle 1, x_active cycle 6, FLUSH cycles 11-41, y_active cycle 42, tile_done cycle 47, cmd_ready cycle 48.
REQ-027 Stale done: w_done held at 1 during the LOAD_W active cycle, low the next cycle -> no early advance; the state advances only on a later w_done.
REQ-028 Timeout: x_done never asserts, TIMEOUT=20 -> err=1, state IDLE, tile_done never pulses; the next accept clears err.
REQ-029 Reset during FLUSH -> next cycle phase=0, busy=0, and no y_active ever asserts.
REQ-030 cmd_valid held high throughout: second tile accepted in the cycle after tile_done; gen_base sequence 0x10, 0x40, 0x80 repeats with the new fields.
REQ-031 A spurious y_done during LOAD_W -> no state change.

Source files
------------

// File: rtl/systolic_tile_scheduler.sv
// Sequences one systolic tile: weight load, input feed, pipeline flush, output drain.
// Start pulses and base addresses are registered together; a stuck generator aborts the tile via timeout.
module systolic_tile_scheduler #(
    parameter int ADDR_WIDTH   = 8,
    parameter int WIDTH_HEIGHT = 16,
    parameter int FLUSH_CYCLES = 31,
    parameter int TIMEOUT      = 1023,
    localparam int CW          = $clog2(WIDTH_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_w_base,
    input  logic [ADDR_WIDTH-1:0] cmd_x_base,
    input  logic [ADDR_WIDTH-1:0] cmd_y_base,
    input  logic [CW-1:0]         cmd_num_row,
    input  logic [CW-1:0]         cmd_num_col,
    output logic                  w_active,
    output logic                  x_active,
    output logic                  y_active,
    input  logic                  w_done,
    input  logic                  x_done,
    input  logic                  y_done,
    output logic [ADDR_WIDTH-1:0] gen_base,
    output logic [CW-1:0]         gen_num_row,
    output logic [CW-1:0]         gen_num_col,
    output logic                  busy,
    output logic [2:0]            phase,
    output logic                  tile_done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        FEED_X  = 3'd2,
        FLUSH   = 3'd3,
        DRAIN_Y = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [9:0] TIMEOUT_W    = 10'(TIMEOUT);
    localparam logic [7:0] FLUSH_LOAD   = 8'(FLUSH_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic                  first_q;
    logic [9:0]            wait_cnt;
    logic [7:0]            flush_cnt;
    logic [ADDR_WIDTH-1:0] w_base_q;
    logic [ADDR_WIDTH-1:0] x_base_q;
    logic [ADDR_WIDTH-1:0] y_base_q;
    logic [CW-1:0]         num_row_q;
    logic [CW-1:0]         num_col_q;
    logic [ADDR_WIDTH-1:0] gen_base_q;
    logic [ADDR_WIDTH-1:0] gen_base_nxt;
    logic                  err_q;

    logic accept;
    logic wait_state;
    logic done_sel;
    logic done_hit;
    logic timeout_hit;
    logic entering;

    assign accept     = cmd_valid && (state == IDLE);
    assign wait_state = (state == LOAD_W) || (state == FEED_X) || (state == DRAIN_Y);
    assign entering   = (state_nxt != state);

    always_comb begin
        done_sel = 1'b0;
        case (state)
            LOAD_W:  done_sel = w_done;
            FEED_X:  done_sel = x_done;
            DRAIN_Y: done_sel = y_done;
            default: done_sel = 1'b0;
        endcase
    end

    // The generator's done level is stale during its start cycle, so only later cycles count.
    assign done_hit    = done_sel && !first_q;
    assign timeout_hit = wait_state && !done_hit && (wait_cnt == TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                if (done_hit)         state_nxt = FEED_X;
                else if (timeout_hit) state_nxt = IDLE;
            end
            FEED_X: begin
                if (done_hit)         state_nxt = FLUSH;
                else if (timeout_hit) state_nxt = IDLE;
            end
            FLUSH: begin
                if (flush_cnt == 8'd0) state_nxt = DRAIN_Y;
            end
            DRAIN_Y: begin
                if (done_hit)         state_nxt = FINISH;
                else if (timeout_hit) state_nxt = IDLE;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        tile_done = 1'b0;
        w_active  = 1'b0;
        x_active  = 1'b0;
        y_active  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD_W:  w_active  = first_q;
            FEED_X:  x_active  = first_q;
            DRAIN_Y: y_active  = first_q;
            FINISH:  tile_done = 1'b1;
            default: ;
        endcase
    end

    // Base address tracks the state being entered so it lines up with the start pulse.
    always_comb begin
        gen_base_nxt = '0;
        case (state_nxt)
            LOAD_W:  gen_base_nxt = accept ? cmd_w_base : w_base_q;
            FEED_X:  gen_base_nxt = x_base_q;
            DRAIN_Y: gen_base_nxt = y_base_q;
            default: gen_base_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_q    <= 1'b0;
            wait_cnt   <= '0;
            flush_cnt  <= '0;
            gen_base_q <= '0;
            err_q      <= 1'b0;
        end else begin
            first_q    <= entering && ((state_nxt == LOAD_W) || (state_nxt == FEED_X) ||
                                       (state_nxt == DRAIN_Y));
            gen_base_q <= gen_base_nxt;

            if (entering) begin
                wait_cnt <= '0;
            end else if (wait_state && (wait_cnt != 10'h3FF)) begin
                wait_cnt <= wait_cnt + 10'd1;
            end

            if ((state_nxt == FLUSH) && (state != FLUSH)) begin
                flush_cnt <= FLUSH_LOAD;
            end else if ((state == FLUSH) && (flush_cnt != 8'd0)) begin
                flush_cnt <= flush_cnt - 8'd1;
            end

            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_base_q  <= '0;
            x_base_q  <= '0;
            y_base_q  <= '0;
            num_row_q <= '0;
            num_col_q <= '0;
        end else if (accept) begin
            w_base_q  <= cmd_w_base;
            x_base_q  <= cmd_x_base;
            y_base_q  <= cmd_y_base;
            num_row_q <= cmd_num_row;
            num_col_q <= cmd_num_col;
        end
    end

    assign gen_base    = gen_base_q;
    assign gen_num_row = num_row_q;
    assign gen_num_col = num_col_q;
    assign phase       = state;
    assign err         = err_q;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Scoreboard bench: each driven tile queues its expected generator starts, the monitor pops them as they appear.
module tb_systolic_tile_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_w_base, cmd_x_base, cmd_y_base;
    logic [3:0] cmd_num_row, cmd_num_col;
    logic       w_active, x_active, y_active;
    logic       w_done, x_done, y_done;
    logic [7:0] gen_base;
    logic [3:0] gen_num_row, gen_num_col;
    logic       busy;
    logic [2:0] phase;
    logic       tile_done;
    logic       err;

    logic [2:0] resp_en;
    logic [2:0] resp_done;
    int         resp_cnt [3];
    logic       w_force, y_force;

    assign w_done = resp_done[0] | w_force;
    assign x_done = resp_done[1];
    assign y_done = resp_done[2] | y_force;

    typedef struct {
        int         kind;
        logic [7:0] base;
        logic [3:0] row;
        logic [3:0] col;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int flush_n = 0;
    int done_cnt = 0;
    int done_abs = 0;
    int t_done = 0;
    int t_act [3];
    int act_cnt [3];

    systolic_tile_scheduler #(
        .ADDR_WIDTH(8), .WIDTH_HEIGHT(16), .FLUSH_CYCLES(31), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_w_base(cmd_w_base), .cmd_x_base(cmd_x_base), .cmd_y_base(cmd_y_base),
        .cmd_num_row(cmd_num_row), .cmd_num_col(cmd_num_col),
        .w_active(w_active), .x_active(x_active), .y_active(y_active),
        .w_done(w_done), .x_done(x_done), .y_done(y_done),
        .gen_base(gen_base), .gen_num_row(gen_num_row), .gen_num_col(gen_num_col),
        .busy(busy), .phase(phase), .tile_done(tile_done), .err(err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] yb,
                             input logic [3:0] r, input logic [3:0] c);
        sb.push_back('{0, wb, r, c});
        sb.push_back('{1, xb, r, c});
        sb.push_back('{2, yb, r, c});
    endtask

    task automatic set_cmd(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] yb,
                           input logic [3:0] r, input logic [3:0] c);
        cmd_w_base  = wb;
        cmd_x_base  = xb;
        cmd_y_base  = yb;
        cmd_num_row = r;
        cmd_num_col = c;
    endtask

    // Returns in the first cycle after the accepting edge.
    task automatic do_accept(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] yb,
                             input logic [3:0] r, input logic [3:0] c);
        bit ok = 0;
        push_tile(wb, xb, yb, r, c);
        set_cmd(wb, xb, yb, r, c);
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            tick();
        end
        cmd_valid = 1'b0;
        chk("accept_wait", 32'(ok), 1);
    endtask

    task automatic wait_done(input int prev);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (done_cnt != prev) ok = 1;
        end
        chk("tile_done_wait", 32'(ok), 1);
    endtask

    // Generator model: done pulses for one cycle, four cycles after its start pulse.
    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            if (resp_done[g]) resp_done[g] = 1'b0;
            if (resp_cnt[g] > 0) begin
                resp_cnt[g]--;
                if (resp_cnt[g] == 0) resp_done[g] = 1'b1;
            end
        end
        if (w_active && resp_en[0]) resp_cnt[0] = 4;
        if (x_active && resp_en[1]) resp_cnt[1] = 4;
        if (y_active && resp_en[2]) resp_cnt[2] = 4;
        if (reset) begin
            resp_done = 3'b000;
            for (int g = 0; g < 3; g++) resp_cnt[g] = 0;
        end
    end

    initial forever begin
        int   kind;
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                flush_n = 0;
            end
            if (phase == 3'd3) flush_n++;
            if (w_active || x_active || y_active) begin
                kind = w_active ? 0 : (x_active ? 1 : 2);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("act_kind", 32'(kind), 32'(e.kind));
                    chk("gen_base", {24'd0, gen_base}, {24'd0, e.base});
                    chk("gen_num_row", {28'd0, gen_num_row}, {28'd0, e.row});
                    chk("gen_num_col", {28'd0, gen_num_col}, {28'd0, e.col});
                end
                t_act[kind] = cyc - acc_cyc;
                act_cnt[kind]++;
            end
            if (tile_done) begin
                done_cnt++;
                done_abs = cyc;
                t_done   = cyc - acc_cyc;
            end
        end
    end

    initial begin
        int prev;
        int ycount;
        bit ok;
        reset = 1'b1;
        cmd_valid = 1'b0;
        set_cmd(8'h0, 8'h0, 8'h0, 4'h0, 4'h0);
        resp_en = 3'b111;
        resp_done = 3'b000;
        w_force = 1'b0;
        y_force = 1'b0;
        for (int g = 0; g < 3; g++) begin
            resp_cnt[g] = 0;
            t_act[g]    = 0;
            act_cnt[g]  = 0;
        end
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_gen_base", 32'(gen_base), 0);
        chk("rst_num", {gen_num_row, gen_num_col}, 0);
        chk("rst_pulses", {w_active, x_active, y_active, tile_done}, 0);
        reset = 1'b0;
        tick();

        // Nominal tile with cycle-exact timing relative to the accept edge.
        prev = done_cnt;
        do_accept(8'h10, 8'h40, 8'h80, 4'd15, 4'd15);
        wait_done(prev);
        chk("t_w_active", 32'(t_act[0]), 1);
        chk("t_x_active", 32'(t_act[1]), 6);
        chk("flush_len", 32'(flush_n), 31);
        chk("t_y_active", 32'(t_act[2]), 42);
        chk("t_tile_done", 32'(t_done), 47);
        chk("ready_after_done", 32'(cmd_ready), 1);
        chk("idle_after_done", 32'(busy), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        // Stale w_done in the start cycle and a spurious y_done must not advance LOAD_W.
        resp_en = 3'b110;
        prev = done_cnt;
        do_accept(8'h21, 8'h52, 8'h93, 4'd3, 4'd7);
        chk("stale_w_active", 32'(w_active), 1);
        w_force = 1'b1;
        tick();
        w_force = 1'b0;
        y_force = 1'b1;
        tick();
        y_force = 1'b0;
        chk("spurious_y_hold", 32'(phase), 1);
        repeat (3) tick();
        chk("stale_hold", 32'(phase), 1);
        w_force = 1'b1;
        tick();
        w_force = 1'b0;
        chk("late_w_advance", 32'(phase), 2);
        resp_en = 3'b111;
        wait_done(prev);
        chk("stale_sb_drained", 32'(sb.size()), 0);
        tick();

        // Generator never finishes: timeout aborts to IDLE with err and no tile_done.
        resp_en = 3'b101;
        prev = done_cnt;
        do_accept(8'h05, 8'h06, 8'h07, 4'd1, 4'd2);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (phase == 3'd0) ok = 1;
        end
        chk("timeout_idle", 32'(ok), 1);
        chk("timeout_err", 32'(err), 1);
        repeat (3) tick();
        chk("timeout_err_sticky", 32'(err), 1);
        chk("timeout_no_done", 32'(done_cnt), 32'(prev));
        chk("timeout_sb_left", 32'(sb.size()), 1);
        sb.delete();
        resp_en = 3'b111;
        prev = done_cnt;
        do_accept(8'h31, 8'h62, 8'hA3, 4'd9, 4'd4);
        chk("err_cleared", 32'(err), 0);
        wait_done(prev);
        tick();

        // Reset in FLUSH aborts the tile; the drain phase must never start.
        do_accept(8'h44, 8'h55, 8'h66, 4'd2, 4'd2);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (phase == 3'd3) ok = 1;
        end
        chk("reach_flush", 32'(ok), 1);
        repeat (5) tick();
        ycount = act_cnt[2];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_flush_phase", 32'(phase), 0);
        chk("rst_flush_busy", 32'(busy), 0);
        chk("rst_flush_pulses", {w_active, x_active, y_active, tile_done}, 0);
        repeat (60) tick();
        chk("rst_flush_no_y", 32'(act_cnt[2]), 32'(ycount));
        sb.delete();

        // cmd_valid held high across two tiles: second accept right after tile_done.
        push_tile(8'h10, 8'h40, 8'h80, 4'd15, 4'd15);
        push_tile(8'h1A, 8'h4B, 8'h8C, 4'd5, 4'd9);
        set_cmd(8'h10, 8'h40, 8'h80, 4'd15, 4'd15);
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            tick();
        end
        chk("b2b_first_accept", 32'(ok), 1);
        set_cmd(8'h1A, 8'h4B, 8'h8C, 4'd5, 4'd9);
        prev = done_cnt;
        wait_done(prev);
        chk("b2b_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_gap", 32'(acc_cyc - done_abs), 1);
        prev = done_cnt;
        wait_done(prev);
        chk("b2b_t_done", 32'(t_done), 47);
        chk("b2b_sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
